multicycle_addsub: RTL

Parametrised, multi-cycle add/subtract unit for the ALU datapath. It is the generalised successor of the fixed 4-bit ripple adder.
- Processes a WIDTH-bit operation as WIDTH/CHUNK sequential CHUNK-bit slices, keeping a narrow carry chain for area and timing.
- Adds subtract mode, carry/overflow/zero flags and a valid/ready handshake on both sides.
- Sits between the ALU operand registers and the result mux.

---
 rtl/multicycle_addsub.sv | 107 ++++++++++
 1 files changed

// File: rtl/multicycle_addsub.sv
// multicycle_addsub: WIDTH-bit add/subtract done as NCHUNK = WIDTH/CHUNK
// sequential CHUNK-bit slices, keeping the carry chain short.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (ready only in IDLE)
//   A, B, Cin, Sub      operands; Sub=1 computes A-B and ignores Cin
//   out_valid/out_ready result handshake (valid only in DONE)
//   Sum, Cout, Ovf, Zero registered result and flags; they change only when
//                       a result completes and hold until the next one
module multicycle_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [WIDTH-1:0]  opa, opb, res;
   logic              carry;
   logic [IDXW-1:0]   idx;

   logic [CHUNK:0]    slice;
   logic [WIDTH-1:0]  res_nxt;
   logic              last;
   logic              msb_cin;

   assign in_ready = (state == IDLE);
   assign last     = (idx == IDXW'(NCHUNK - 1));

   // One slice of the add; opb already holds ~B for subtract, carry holds 1.
   always_comb begin
      slice = {1'b0, opa[idx*CHUNK +: CHUNK]} + {1'b0, opb[idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
      res_nxt = res;
      res_nxt[idx*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      // Carry into the MSB recovered from its sum bit; meaningful on the last slice.
      msb_cin = opa[WIDTH-1] ^ opb[WIDTH-1] ^ res_nxt[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         opa       <= '0;
         opb       <= '0;
         res       <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         out_valid <= 1'b0;
         Sum       <= '0;
         Cout      <= 1'b0;
         Ovf       <= 1'b0;
         Zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa   <= A;
                  opb   <= Sub ? ~B : B;
                  carry <= Sub ? 1'b1 : Cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               res   <= res_nxt;
               carry <= slice[CHUNK];
               idx   <= idx + IDXW'(1);
               if (last) begin
                  Sum       <= res_nxt;
                  Cout      <= slice[CHUNK];
                  Ovf       <= msb_cin ^ slice[CHUNK];
                  Zero      <= ~|res_nxt;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
